// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - Fibonacci/Galois LFSR with period measurement, threshold compare and lockup guard.
module lfsr_gen #(
  parameter int              WIDTH = 4,
  parameter int              MODE  = 0,
  parameter logic [WIDTH-1:0] POLY = 4'b1100,
  parameter logic [WIDTH-1:0] SEED = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] threshold,
  output logic [WIDTH-1:0] state,
  output logic             bit_out,
  output logic             above,
  output logic             period_done,
  output logic [WIDTH-1:0] period_len,
  output logic             lockup
);

  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] r_start;
  logic [WIDTH-1:0] r_step_cnt;
  logic [WIDTH-1:0] r_period_len;
  logic             r_period_done;
  logic             r_lockup;

  logic [WIDTH-1:0] w_step;
  logic [WIDTH-1:0] w_next;
  logic             w_load_zero;
  logic             w_wrap;

  generate
    if (MODE == 0) begin : g_fib
      assign w_step = {r_state[WIDTH-2:0], ^(r_state & POLY)};
    end else begin : g_gal
      assign w_step = {r_state[WIDTH-2:0], 1'b0} ^ (r_state[WIDTH-1] ? POLY : '0);
    end
  endgenerate

  // A degenerate tap mask could step into zero; fall back to SEED so zero stays unreachable.
  assign w_next      = (w_step == '0) ? SEED : w_step;
  assign w_load_zero = (load_value == '0);
  assign w_wrap      = (w_next == r_start);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= SEED;
      r_start       <= SEED;
      r_step_cnt    <= '0;
      r_period_len  <= '0;
      r_period_done <= 1'b0;
      r_lockup      <= 1'b0;
    end else begin
      r_period_done <= 1'b0;
      r_lockup      <= 1'b0;
      if (load) begin
        r_state    <= w_load_zero ? SEED : load_value;
        r_start    <= w_load_zero ? SEED : load_value;
        r_step_cnt <= '0;
        r_lockup   <= w_load_zero;
      end else if (en) begin
        r_state <= w_next;
        if (w_wrap) begin
          r_period_done <= 1'b1;
          r_period_len  <= r_step_cnt + 1'b1;
          r_step_cnt    <= '0;
        end else begin
          r_step_cnt <= r_step_cnt + 1'b1;
        end
      end
    end
  end

  assign state       = r_state;
  assign bit_out     = r_state[WIDTH-1];
  assign above       = (r_state > threshold);
  assign period_done = r_period_done;
  assign period_len  = r_period_len;
  assign lockup      = r_lockup;

endmodule

// File: tb/tb_lfsr_gen.sv
// tb/tb_lfsr_gen.sv - scoreboard bench for lfsr_gen: Fibonacci default instance and Galois instance.
module tb_lfsr_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_value = 4'd0;
  logic [3:0] threshold = 4'd10;

  logic [1:0][3:0] st;
  logic [1:0][3:0] pl;
  logic [1:0]      bo, ab, pd, lk;

  lfsr_gen u_fib (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_value(load_value),
    .threshold(threshold), .state(st[0]), .bit_out(bo[0]), .above(ab[0]),
    .period_done(pd[0]), .period_len(pl[0]), .lockup(lk[0])
  );

  lfsr_gen #(.WIDTH(4), .MODE(1), .POLY(4'b0011), .SEED(4'b1111)) u_gal (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_value(load_value),
    .threshold(threshold), .state(st[1]), .bit_out(bo[1]), .above(ab[1]),
    .period_done(pd[1]), .period_len(pl[1]), .lockup(lk[1])
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0][3:0] st;
    logic [1:0][3:0] pl;
    logic [1:0]      ab;
    logic [1:0]      pd;
    logic [1:0]      lk;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: per instance start value plus a plain step counter.
  int m_state[2], m_start[2], m_cnt[2], m_plen[2];
  bit m_pd[2], m_lk[2];
  int poly_m[2] = '{12, 3};

  bit        tracking = 0;
  logic [15:0] seen_mask = '0;

  function automatic int model_step(int k, int s);
    int n, t, p;
    if (k == 0) begin
      t = s & poly_m[0];
      p = 0;
      while (t != 0) begin
        p = p ^ (t & 1);
        t = t >> 1;
      end
      n = ((s * 2) % 16) + p;
    end else begin
      n = s * 2;
      if (n >= 16) n = (n - 16) ^ poly_m[1];
    end
    if (n == 0) n = 15;
    return n;
  endfunction

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic cycle(input bit r, input bit ld, input int lv, input bit e, input int thr);
    exp_t x;
    int   n;
    @(negedge clk);
    rst = r; load = ld; load_value = lv[3:0]; en = e; threshold = thr[3:0];
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        m_state[k] = 15; m_start[k] = 15; m_cnt[k] = 0; m_plen[k] = 0;
        m_pd[k] = 0; m_lk[k] = 0;
      end else begin
        m_pd[k] = 0; m_lk[k] = 0;
        if (ld) begin
          m_state[k] = (lv == 0) ? 15 : lv;
          m_start[k] = m_state[k];
          m_cnt[k] = 0;
          m_lk[k] = (lv == 0);
        end else if (e) begin
          n = model_step(k, m_state[k]);
          if (n == m_start[k]) begin
            m_pd[k] = 1; m_plen[k] = (m_cnt[k] + 1) % 16; m_cnt[k] = 0;
          end else begin
            m_cnt[k] = (m_cnt[k] + 1) % 16;
          end
          m_state[k] = n;
        end
      end
      x.st[k] = m_state[k][3:0];
      x.pl[k] = m_plen[k][3:0];
      x.ab[k] = (m_state[k] > thr);
      x.pd[k] = m_pd[k];
      x.lk[k] = m_lk[k];
    end
    q.push_back(x);
    if (r) begin
      #1;
      check("async_rst_state", int'(st[0]), 15);
      check("async_rst_period_len", int'(pl[0]), 0);
    end
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() != 0) begin
        x = q.pop_front();
        for (int k = 0; k < 2; k++) begin
          check($sformatf("state[%0d]", k), int'(st[k]), int'(x.st[k]));
          check($sformatf("bit_out[%0d]", k), int'(bo[k]), int'(x.st[k][3]));
          check($sformatf("above[%0d]", k), int'(ab[k]), int'(x.ab[k]));
          check($sformatf("period_done[%0d]", k), int'(pd[k]), int'(x.pd[k]));
          check($sformatf("period_len[%0d]", k), int'(pl[k]), int'(x.pl[k]));
          check($sformatf("lockup[%0d]", k), int'(lk[k]), int'(x.lk[k]));
        end
        if (tracking) seen_mask[st[0]] = 1'b1;
      end
    end
  end

  initial begin : driver
    int lv;
    repeat (2) cycle(1, 0, 0, 0, 10);
    repeat (2) cycle(0, 0, 0, 0, 10);

    seen_mask = '0;
    tracking = 1;
    repeat (15) cycle(0, 0, 0, 1, 10);
    #8;
    tracking = 0;
    check("distinct_states", $countones(seen_mask), 15);
    check("zero_state_seen", int'(seen_mask[0]), 0);
    repeat (5) cycle(0, 0, 0, 1, 10);

    cycle(0, 1, 1, 0, 10);
    repeat (18) cycle(0, 0, 0, 1, 10);

    cycle(0, 1, 5, 1, 10);
    repeat (4) cycle(0, 0, 0, 1, 10);
    repeat (3) cycle(0, 0, 0, 0, 10);
    repeat (3) cycle(0, 0, 0, 1, 10);

    cycle(0, 1, 0, 0, 10);
    repeat (2) cycle(0, 0, 0, 1, 10);

    cycle(0, 1, 15, 0, 10);
    repeat (7) cycle(0, 0, 0, 1, 10);
    cycle(1, 0, 0, 1, 10);
    repeat (5) cycle(0, 0, 0, 1, 10);

    for (int i = 0; i < 400; i++) begin
      lv = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 15));
      cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0), lv,
            ($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)));
    end

    repeat (2) cycle(0, 0, 0, 0, 10);
    for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
